led_scan_sequencer: RTL and testbench



---
 rtl/led_scan_sequencer_pkg.sv | 21 ++
 rtl/led_valid_delay.sv | 26 ++
 rtl/led_scan_sequencer.sv | 113 +++++++++++
 tb/tb_led_scan_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_scan_sequencer_pkg.sv
// Shared encodings and panel geometry for the 1/32-scan HUB75 row sequencer.
package led_scan_sequencer_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_BLANK = 3'd3;
    localparam logic [2:0] ST_LATCH = 3'd4;
    localparam logic [2:0] ST_POST  = 3'd5;

    localparam int PANEL_COLS      = 64;
    localparam int PANEL_HALF_ROWS = 32;
    localparam int SHIFTS_PER_ROW  = 2 * PANEL_COLS;

    // Tag carried alongside each painter request through its latency.
    typedef struct packed {
        logic valid;
        logic bottom;
    } pix_tag_t;

endpackage

// File: rtl/led_valid_delay.sv
// Fixed-latency shift register that tracks painter requests until rgb24 is valid.
module led_valid_delay
    import led_scan_sequencer_pkg::*;
#(
    parameter int DELAY = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  pix_tag_t tag_in,
    output pix_tag_t tag_out
);

    pix_tag_t [DELAY:1] vld_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= tag_in;
            for (int i = 2; i <= DELAY; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign tag_out = vld_pipe[DELAY];

endmodule

// File: rtl/led_scan_sequencer.sv
// Row sequencer: painter request stream, pixel strobe alignment, blank/latch timing, PWM counters.
module led_scan_sequencer
    import led_scan_sequencer_pkg::*;
#(
    parameter int FRAME_BITS   = 12,
    parameter int DELAY        = 2,
    parameter int SUBFRAMES    = 256,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [FRAME_BITS-1:0] frame,
    output logic [7:0]            subframe,
    output logic [5:0]            x,
    output logic [5:0]            y,
    output logic                  req_valid,
    output logic                  pix_valid,
    output logic                  pix_bottom,
    output logic                  shift_clk_en,
    output logic [4:0]            row_addr,
    output logic                  blank,
    output logic                  latch,
    output logic                  frame_done
);

    logic [2:0] state;
    logic [6:0] cnt;
    logic [4:0] shift_row;
    logic       en_q;
    logic       latched_once;
    logic       last_cnt;
    pix_tag_t   tag_in;
    pix_tag_t   tag_out;

    // One shared phase counter; last_cnt marks the final cycle of the current state.
    always_comb begin
        last_cnt = 1'b1;
        case (state)
            ST_SHIFT:          last_cnt = (cnt == 7'(SHIFTS_PER_ROW - 1));
            ST_DRAIN:          last_cnt = (cnt == 7'(DELAY - 1));
            ST_BLANK, ST_POST: last_cnt = (cnt == 7'(BLANK_CYCLES - 1));
            default:           last_cnt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            shift_row    <= '0;
            subframe     <= '0;
            frame        <= '0;
            row_addr     <= '0;
            frame_done   <= 1'b0;
            en_q         <= 1'b0;
            latched_once <= 1'b0;
        end else begin
            en_q       <= enable;
            frame_done <= 1'b0;
            cnt        <= last_cnt ? '0 : cnt + 7'd1;
            case (state)
                ST_IDLE:  if (en_q) state <= ST_SHIFT;
                ST_SHIFT: if (last_cnt) state <= ST_DRAIN;
                ST_DRAIN: if (last_cnt) state <= ST_BLANK;
                ST_BLANK: if (last_cnt) begin
                    state        <= ST_LATCH;
                    row_addr     <= shift_row;
                    latched_once <= 1'b1;
                end
                ST_LATCH: state <= ST_POST;
                ST_POST: if (last_cnt) begin
                    state <= enable ? ST_SHIFT : ST_IDLE;
                    if (shift_row == 5'(PANEL_HALF_ROWS - 1)) begin
                        shift_row <= '0;
                        if (subframe == 8'(SUBFRAMES - 1)) begin
                            subframe   <= '0;
                            frame      <= frame + FRAME_BITS'(1);
                            frame_done <= 1'b1;
                        end else begin
                            subframe <= subframe + 8'd1;
                        end
                    end else begin
                        shift_row <= shift_row + 5'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Top pixel of each column first (c[0]=0), bottom half second.
    assign req_valid = (state == ST_SHIFT);
    assign x         = cnt[6:1];
    assign y         = {cnt[0], shift_row};
    assign latch     = (state == ST_LATCH);
    assign blank     = !((state == ST_SHIFT) || (state == ST_DRAIN)) || !latched_once;

    assign tag_in.valid  = req_valid;
    assign tag_in.bottom = req_valid & cnt[0];

    led_valid_delay #(.DELAY(DELAY)) u_valid_delay (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign pix_valid    = tag_out.valid;
    assign pix_bottom   = tag_out.bottom;
    assign shift_clk_en = tag_out.valid & tag_out.bottom;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// Default, short-frame (SUBFRAMES=2, FRAME_BITS=2) and DELAY=7 instances run side by side;
// stimulus pushes expectations into queues, a negedge monitor pops and compares.
module tb_led_scan_sequencer;

    localparam int A_DELAY = 2;

    typedef enum int {S_FRAME, S_SUBFRAME, S_X, S_Y, S_REQ, S_PIX, S_BOT, S_SHCLK,
                      S_ROW, S_BLANK, S_LATCH, S_FD, S_QREQ, S_QLAT, S_CONST} sig_e;
    typedef struct {
        string name;
        sig_e  id;
        int    exp;
        int    val;
    } probe_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_reset = 1'b1, a_en = 1'b0, a_chk = 1'b0;
    logic [11:0] a_frame;
    logic [7:0]  a_subframe;
    logic [5:0]  a_x, a_y;
    logic        a_req_valid, a_pix_valid, a_pix_bottom, a_shift_clk_en;
    logic [4:0]  a_row_addr;
    logic        a_blank, a_latch, a_frame_done;

    logic b_reset = 1'b1, b_en = 1'b0;
    logic [1:0]  b_frame;
    logic [7:0]  b_subframe;
    logic [5:0]  b_x, b_y;
    logic        b_req_valid, b_pix_valid, b_pix_bottom, b_shift_clk_en;
    logic [4:0]  b_row_addr;
    logic        b_blank, b_latch, b_frame_done;

    logic c_reset = 1'b1, c_en = 1'b0;
    logic [11:0] c_frame;
    logic [7:0]  c_subframe;
    logic [5:0]  c_x, c_y;
    logic        c_req_valid, c_pix_valid, c_pix_bottom, c_shift_clk_en;
    logic [4:0]  c_row_addr;
    logic        c_blank, c_latch, c_frame_done;

    led_scan_sequencer #(.FRAME_BITS(12), .DELAY(A_DELAY), .SUBFRAMES(256), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .reset(a_reset), .enable(a_en), .frame(a_frame), .subframe(a_subframe),
        .x(a_x), .y(a_y), .req_valid(a_req_valid), .pix_valid(a_pix_valid),
        .pix_bottom(a_pix_bottom), .shift_clk_en(a_shift_clk_en), .row_addr(a_row_addr),
        .blank(a_blank), .latch(a_latch), .frame_done(a_frame_done));

    led_scan_sequencer #(.FRAME_BITS(2), .DELAY(2), .SUBFRAMES(2), .BLANK_CYCLES(2)) dut_b (
        .clk(clk), .reset(b_reset), .enable(b_en), .frame(b_frame), .subframe(b_subframe),
        .x(b_x), .y(b_y), .req_valid(b_req_valid), .pix_valid(b_pix_valid),
        .pix_bottom(b_pix_bottom), .shift_clk_en(b_shift_clk_en), .row_addr(b_row_addr),
        .blank(b_blank), .latch(b_latch), .frame_done(b_frame_done));

    led_scan_sequencer #(.FRAME_BITS(12), .DELAY(7), .SUBFRAMES(256), .BLANK_CYCLES(2)) dut_c (
        .clk(clk), .reset(c_reset), .enable(c_en), .frame(c_frame), .subframe(c_subframe),
        .x(c_x), .y(c_y), .req_valid(c_req_valid), .pix_valid(c_pix_valid),
        .pix_bottom(c_pix_bottom), .shift_clk_en(c_shift_clk_en), .row_addr(c_row_addr),
        .blank(c_blank), .latch(c_latch), .frame_done(c_frame_done));

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int errors = 0, checks = 0;
    int qreq[$], qpix[$], qlat[$], qfr[$];
    probe_t probe_q[$];

    int a_nlat = 0, a_first_req = 0, a_lat_cyc = 0, a_shifts = 0;
    logic [6:0] a_hist = '0;
    int b_nlat = 0, b_nfd = 0;
    logic b_fd_prev = 1'b0;
    int c_nlat = 0, c_first_req = 0, c_first_pix = 0, c_prev_lat = 0, c_last_sh = 0, c_shifts = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int sig_a(input sig_e id, input int v);
        case (id)
            S_FRAME:    return int'(a_frame);
            S_SUBFRAME: return int'(a_subframe);
            S_X:        return int'(a_x);
            S_Y:        return int'(a_y);
            S_REQ:      return int'(a_req_valid);
            S_PIX:      return int'(a_pix_valid);
            S_BOT:      return int'(a_pix_bottom);
            S_SHCLK:    return int'(a_shift_clk_en);
            S_ROW:      return int'(a_row_addr);
            S_BLANK:    return int'(a_blank);
            S_LATCH:    return int'(a_latch);
            S_FD:       return int'(a_frame_done);
            S_QREQ:     return qreq.size();
            S_QLAT:     return qlat.size();
            default:    return v;
        endcase
    endfunction

    // Monitor: sole owner of the check counters.
    initial begin
        probe_t p;
        int e;
        forever begin
            @(negedge clk);
            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                chk(p.name, sig_a(p.id, p.val), p.exp);
            end
            if (a_chk) begin
                if (a_req_valid) begin
                    if (a_first_req == 0) a_first_req = cyc;
                    if (qreq.size() == 0) chk("a_req_unexpected", 1, 0);
                    else begin
                        e = qreq.pop_front();
                        chk("a_req_xy", int'({a_x, a_y}), e);
                        qpix.push_back((cyc + A_DELAY) * 2 + ((e >> 5) & 1));
                    end
                end
                if (a_pix_valid) begin
                    if (qpix.size() == 0) chk("a_pix_unexpected", 1, 0);
                    else begin
                        e = qpix.pop_front();
                        chk("a_pix_time", cyc, e / 2);
                        chk("a_pix_bottom", int'(a_pix_bottom), e % 2);
                    end
                end
                if (a_shift_clk_en) a_shifts++;
                a_hist = {a_hist[5:0], a_blank};
                if (a_latch) begin
                    a_nlat++;
                    if (qlat.size() == 0) chk("a_latch_unexpected", 1, 0);
                    else chk("a_row_addr", int'(a_row_addr), qlat.pop_front());
                    chk("a_shifts_per_row", a_shifts, 64);
                    a_shifts = 0;
                    if (a_nlat >= 2 && a_nlat <= 33) chk("a_row_period", cyc - a_lat_cyc, 135);
                    a_lat_cyc = cyc;
                end
                // DRAIN, BLANK x2, LATCH, POST x2, SHIFT around each latch
                if (a_nlat >= 2 && a_nlat <= 33 && cyc == a_lat_cyc + 3)
                    chk("a_blank_window", int'(a_hist), 'b0111110);
            end
            if (b_latch) b_nlat++;
            if (b_fd_prev) chk("b_frame_done_width", int'(b_frame_done), 0);
            if (b_frame_done) begin
                if (qfr.size() == 0) chk("b_frame_done_unexpected", 1, 0);
                else chk("b_frame", int'(b_frame), qfr.pop_front());
                chk("b_latches_at_wrap", b_nlat, 64 * (b_nfd + 1));
                chk("b_subframe_at_wrap", int'(b_subframe), 0);
                b_nfd++;
            end
            b_fd_prev = b_frame_done;
            if (c_req_valid && c_first_req == 0) c_first_req = cyc;
            if (c_pix_valid && c_first_pix == 0) begin
                c_first_pix = cyc;
                chk("c_pix_lag", cyc - c_first_req, 7);
            end
            if (c_shift_clk_en) begin
                c_shifts++;
                c_last_sh = cyc;
            end
            if (c_latch) begin
                c_nlat++;
                chk("c_shifts_per_row", c_shifts, 64);
                c_shifts = 0;
                chk("c_last_shift_before_blank", cyc - c_last_sh, 3);
                if (c_nlat >= 2) chk("c_row_period", cyc - c_prev_lat, 140);
                c_prev_lat = cyc;
            end
        end
    end

    task automatic probe(input string n, input sig_e id, input int exp);
        probe_t p;
        p.name = n; p.id = id; p.exp = exp; p.val = 0;
        probe_q.push_back(p);
    endtask

    task automatic fail_const(input string n);
        probe_t p;
        p.name = n; p.id = S_CONST; p.exp = 0; p.val = 1;
        probe_q.push_back(p);
    endtask

    task automatic probe_reset(input string t);
        probe({t, "_frame"}, S_FRAME, 0);      probe({t, "_subframe"}, S_SUBFRAME, 0);
        probe({t, "_x"}, S_X, 0);              probe({t, "_y"}, S_Y, 0);
        probe({t, "_req_valid"}, S_REQ, 0);    probe({t, "_pix_valid"}, S_PIX, 0);
        probe({t, "_pix_bottom"}, S_BOT, 0);   probe({t, "_shift_clk_en"}, S_SHCLK, 0);
        probe({t, "_row_addr"}, S_ROW, 0);     probe({t, "_blank"}, S_BLANK, 1);
        probe({t, "_latch"}, S_LATCH, 0);      probe({t, "_frame_done"}, S_FD, 0);
    endtask

    task automatic push_row(input int sr);
        for (int c = 0; c < 128; c++) qreq.push_back((c / 2) * 64 + sr + 32 * (c % 2));
    endtask

    function automatic int count_of(input int which);
        case (which)
            0:       return a_nlat;
            1:       return b_nfd;
            default: return c_nlat;
        endcase
    endfunction

    task automatic wait_until(input int which, input int target, input int budget, input string n);
        int g = 0;
        while (count_of(which) < target && g < budget) begin
            @(posedge clk); #1;
            g++;
        end
        if (count_of(which) < target) fail_const(n);
    endtask

    initial begin
        int rel, g;
        logic prev;
        repeat (3) @(posedge clk);
        #1;
        probe_reset("a_rst");
        for (int r = 0; r < 34; r++) begin
            push_row(r % 32);
            qlat.push_back(r % 32);
        end
        qfr.push_back(1); qfr.push_back(2); qfr.push_back(3); qfr.push_back(0);
        rel = cyc;
        a_reset = 1'b0; a_en = 1'b1; a_chk = 1'b1;
        b_reset = 1'b0; b_en = 1'b1;
        c_reset = 1'b0; c_en = 1'b1;

        g = 0;
        while (a_first_req == 0 && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (a_first_req == 0) fail_const("timeout_a_first_req");
        else begin
            probe_t p;
            p.name = "a_first_req_latency"; p.id = S_CONST; p.exp = 2; p.val = a_first_req - rel;
            probe_q.push_back(p);
        end

        // 33 latches: row_addr 0..31 then 0, subframe advanced once
        wait_until(0, 33, 33 * 135 + 100, "timeout_a_33_latches");
        probe("a_subframe_after_32_rows", S_SUBFRAME, 1);
        probe("a_frame_after_32_rows", S_FRAME, 0);
        probe("a_row_addr_wrapped", S_ROW, 0);

        // drop enable at SHIFT c=40 of shift_row 1
        g = 0;
        while (!(a_req_valid && a_x == 6'd20 && a_y == 6'd1) && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 300) fail_const("timeout_a_c40");
        a_en = 1'b0;
        wait_until(0, 34, 300, "timeout_a_latch_after_drop");
        repeat (2) @(posedge clk);
        #1;
        probe("a_idle_blank", S_BLANK, 1);
        probe("a_idle_subframe_kept", S_SUBFRAME, 1);
        probe("a_idle_frame_kept", S_FRAME, 0);
        for (int i = 0; i < 10; i++) begin
            probe("a_idle_no_req", S_REQ, 0);
            @(posedge clk); #1;
        end

        push_row(2); push_row(3);
        qlat.push_back(2);
        a_en = 1'b1;
        wait_until(0, 35, 300, "timeout_a_resume_latch");
        probe("a_resume_subframe", S_SUBFRAME, 1);

        // reset in the first DRAIN cycle of shift_row 3
        prev = 1'b0;
        g = 0;
        while (g < 300) begin
            @(posedge clk); #1;
            g++;
            if (prev && !a_req_valid) break;
            prev = a_req_valid;
        end
        if (g >= 300) fail_const("timeout_a_drain");
        a_chk = 1'b0;
        a_reset = 1'b1;
        @(posedge clk); #1;
        probe_reset("a_drain_rst");
        probe("a_req_queue_drained", S_QREQ, 0);
        probe("a_latch_queue_drained", S_QLAT, 0);
        qpix.delete();
        a_reset = 1'b0;
        a_en = 1'b0;
        for (int i = 0; i < A_DELAY + 3; i++) begin
            @(posedge clk); #1;
            probe("a_no_stale_pix", S_PIX, 0);
            probe("a_no_req_after_rst", S_REQ, 0);
        end

        wait_until(2, 3, 1000, "timeout_c_latches");
        wait_until(1, 4, 256 * 135 + 2000, "timeout_b_frames");
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
